// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous framebuffer RAM between
// the VGA scanout reader and the GPU. Scanout wins during the active area,
// the GPU wins during blanking, and a sole requester always wins.
// Every access is issued one cycle after its grant edge. Read data returns
// two edges after the grant and is steered back by a two-stage owner tag.
//
// Optional feature: define VRAM_ARBITER_STALL_COUNT_EN to build a saturating
// GPU wait-cycle counter on gpu_stall_count. Without the macro, the port is
// tied to zero.
module vram_arbiter #(
  parameter int addr_width = 16,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  blanking,
  input  logic                  scan_req,
  input  logic [addr_width-1:0] scan_addr,
  output logic                  scan_grant,
  output logic [data_width-1:0] scan_data,
  output logic                  scan_valid,
  input  logic                  gpu_req,
  input  logic                  gpu_we,
  input  logic [addr_width-1:0] gpu_addr,
  input  logic [data_width-1:0] gpu_wdata,
  output logic                  gpu_grant,
  output logic [data_width-1:0] gpu_rdata,
  output logic                  gpu_rvalid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_wdata,
  input  logic [data_width-1:0] mem_rdata,
  output logic [15:0]           gpu_stall_count
);

  // Owner of an access, which decides where its read data goes.
  // GPU writes return nothing, so they travel as TAG_NONE.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_SCAN = 2'd1,
    TAG_GPU  = 2'd2
  } tag_t;

  logic grant_scan;
  logic grant_gpu;
  tag_t tag_p0;
  tag_t tag_p1;

  // Arbitration decision for the current edge: blanking selects the winner
  // only when both sides request.
  always_comb begin
    grant_scan = 1'b0;
    grant_gpu  = 1'b0;
    if (scan_req && gpu_req) begin
      grant_gpu  = blanking;
      grant_scan = ~blanking;
    end else begin
      grant_scan = scan_req;
      grant_gpu  = gpu_req;
    end
  end

  // ---- stage p0: grant strobes, RAM command and owner tag ----
  // Register the grant strobes, RAM command and owner tag for the winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_grant <= 1'b0;
      gpu_grant  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      tag_p0     <= TAG_NONE;
    end else begin
      scan_grant <= grant_scan;
      gpu_grant  <= grant_gpu;
      mem_en     <= grant_scan | grant_gpu;
      mem_we     <= grant_gpu & gpu_we;
      tag_p0     <= TAG_NONE;
      if (grant_scan) begin
        mem_addr  <= scan_addr;
        mem_wdata <= '0;
        tag_p0    <= TAG_SCAN;
      end else if (grant_gpu) begin
        mem_addr  <= gpu_addr;
        mem_wdata <= gpu_we ? gpu_wdata : '0;
        tag_p0    <= gpu_we ? TAG_NONE : TAG_GPU;
      end
    end
  end

  // ---- stage p1: RAM is reading, tag waits one cycle for the data ----
  // Delay the owner tag to line up with the RAM read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_p1 <= TAG_NONE;
    end else begin
      tag_p1 <= tag_p0;
    end
  end

  // ---- stage p2: read data returned to its owner ----
  // Capture RAM data for the tagged owner; each data register holds between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_valid <= 1'b0;
      gpu_rvalid <= 1'b0;
      scan_data  <= '0;
      gpu_rdata  <= '0;
    end else begin
      scan_valid <= (tag_p1 == TAG_SCAN);
      gpu_rvalid <= (tag_p1 == TAG_GPU);
      if (tag_p1 == TAG_SCAN) begin
        scan_data <= mem_rdata;
      end
      if (tag_p1 == TAG_GPU) begin
        gpu_rdata <= mem_rdata;
      end
    end
  end

`ifdef VRAM_ARBITER_STALL_COUNT_EN
  // Increment by one, but stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_cnt;

  // Count edges where the GPU is asking but someone else holds the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (gpu_req && !grant_gpu) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign gpu_stall_count = stall_cnt;
`else
  assign gpu_stall_count = 16'd0;
`endif

endmodule
